// File: rtl/cplx_div_if.sv
// Operand/result handshake bundle for the complex divider.
// valid/ready: a transfer happens on a rising clk edge where both valid and ready are high.
interface cplx_div_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_re;
  logic signed [WIDTH-1:0] a_im;
  logic signed [WIDTH-1:0] b_re;
  logic signed [WIDTH-1:0] b_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] y_re;
  logic signed [WIDTH-1:0] y_im;
  logic                    div_by_zero;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_valid, y_re, y_im, div_by_zero
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_valid, y_re, y_im, div_by_zero
  );
endinterface

// File: rtl/cplx_div.sv
// Iterative fixed-point complex divider y = a / b using restoring division,
// one quotient bit per cycle for the real and imaginary parts in parallel.
module cplx_div #(
  parameter int WIDTH       = 16,
  parameter int FIXED_POINT = 8
) (
  input  logic        clk,
  input  logic        rst,
  cplx_div_if.slave   bus,
  output logic [1:0]  dbg_state
);
  localparam int P_W      = 2 * WIDTH;
  localparam int S_W      = 2 * WIDTH + 1;
  localparam int DIV_BITS = 2 * WIDTH + FIXED_POINT + 1;
  localparam int CNT_W    = $clog2(DIV_BITS);
  localparam logic [DIV_BITS-1:0] POS_LIM = {{(DIV_BITS-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, OUT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] ar, ai, br, bi;
  logic [S_W-1:0]          den_q;
  logic [DIV_BITS-1:0]     dvd_re, dvd_im, quo_re, quo_im;
  logic [S_W:0]            rem_re, rem_im;
  logic                    neg_re, neg_im, zero_re, zero_im, dbz;

  logic signed [P_W-1:0]   p_rr, p_ii, p_ir, p_ri, p_bbr, p_bbi;
  logic signed [S_W-1:0]   num_re, num_im;
  logic [S_W-1:0]          den_c, mag_re, mag_im;
  logic [S_W:0]            trial_re, trial_im, nrem_re, nrem_im;
  logic                    ge_re, ge_im;
  logic [DIV_BITS-1:0]     nquo_re, nquo_im;

  assign dbg_state = state;

  always_comb begin
    p_rr   = P_W'(ar) * P_W'(br);
    p_ii   = P_W'(ai) * P_W'(bi);
    p_ir   = P_W'(ai) * P_W'(br);
    p_ri   = P_W'(ar) * P_W'(bi);
    p_bbr  = P_W'(br) * P_W'(br);
    p_bbi  = P_W'(bi) * P_W'(bi);
    num_re = S_W'(p_rr) + S_W'(p_ii);
    num_im = S_W'(p_ir) - S_W'(p_ri);
    den_c  = $unsigned(S_W'(p_bbr) + S_W'(p_bbi));
    mag_re = num_re[S_W-1] ? $unsigned(-num_re) : $unsigned(num_re);
    mag_im = num_im[S_W-1] ? $unsigned(-num_im) : $unsigned(num_im);
    // Remainder stays below den, so dropping its MSB on the shift loses nothing.
    trial_re = {rem_re[S_W-1:0], dvd_re[DIV_BITS-1]};
    trial_im = {rem_im[S_W-1:0], dvd_im[DIV_BITS-1]};
    ge_re    = trial_re >= {1'b0, den_q};
    ge_im    = trial_im >= {1'b0, den_q};
    nrem_re  = ge_re ? trial_re - {1'b0, den_q} : trial_re;
    nrem_im  = ge_im ? trial_im - {1'b0, den_q} : trial_im;
    nquo_re  = {quo_re[DIV_BITS-2:0], ge_re};
    nquo_im  = {quo_im[DIV_BITS-2:0], ge_im};
  end

  // Re-apply sign and clamp; on divide-by-zero only the numerator sign matters.
  function automatic logic signed [WIDTH-1:0] finish(input logic [DIV_BITS-1:0] q,
                                                     input logic neg, input logic zero,
                                                     input logic dz);
    if (dz)       return zero ? '0 : (neg ? MIN_NEG : MAX_POS);
    else if (neg) return (q > POS_LIM) ? MIN_NEG : -q[WIDTH-1:0];
    else          return (q > POS_LIM) ? MAX_POS : q[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.y_re        <= '0;
      bus.y_im        <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ar           <= bus.a_re;
          ai           <= bus.a_im;
          br           <= bus.b_re;
          bi           <= bus.b_im;
          bus.in_ready <= 1'b0;
          state        <= MUL;
        end
        MUL: begin
          den_q   <= den_c;
          dvd_re  <= {mag_re, {FIXED_POINT{1'b0}}};
          dvd_im  <= {mag_im, {FIXED_POINT{1'b0}}};
          rem_re  <= '0;
          rem_im  <= '0;
          quo_re  <= '0;
          quo_im  <= '0;
          neg_re  <= num_re[S_W-1];
          neg_im  <= num_im[S_W-1];
          zero_re <= (num_re == '0);
          zero_im <= (num_im == '0);
          dbz     <= (den_c == '0);
          cnt     <= CNT_W'(DIV_BITS - 1);
          state   <= DIV;
        end
        DIV: begin
          dvd_re <= dvd_re << 1;
          dvd_im <= dvd_im << 1;
          rem_re <= nrem_re;
          rem_im <= nrem_im;
          quo_re <= nquo_re;
          quo_im <= nquo_im;
          if (cnt == '0) begin
            bus.y_re        <= finish(nquo_re, neg_re, zero_re, dbz);
            bus.y_im        <= finish(nquo_im, neg_im, zero_im, dbz);
            bus.div_by_zero <= dbz;
            bus.out_valid   <= 1'b1;
            state           <= OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
